alu_in_deserializer: RTL and testbench
======================================

Name: alu_in_deserializer

Overview:
- Receiving end of the ALU serial input protocol. Sits at the ALU input and reassembles the packets sent on `sin` into operands A and B and an operation code.
- Counts data packets, checks the 4-bit command CRC and flags malformed frames.
- Delivers one registered result per frame to the ALU core, along with error flags for the core's error-response path.

Parameters:
- DATA_PACKETS, 8, number of data packets per well-formed frame (4 for A, then 4 for B).
- CRC_INIT, 4'b0000, initial CRC register value at the start of each frame.

Ports:
- clk  input  1  system clock; one serial bit per rising edge.
- rst_n  input  1  synchronous active-low reset.
- sin  input  1  serial input line; idle high.
- out_valid  output  1  one-cycle pulse: frame complete, outputs below are valid.
- A  output  32  operand A, first data byte received is the MSB byte.
- B  output  32  operand B, same byte order.
- op  output  3  operation code from the command packet.
- err_data  output  1  with out_valid: data packet count ≠ DATA_PACKETS.
- err_crc  output  1  with out_valid: CRC mismatch, packet count correct.
- err_frame  output  1  one-cycle pulse: a packet had a stop bit of 0.

Behaviour:
- Packet format: 11 bits, in order:
  - start bit 0;
  - type bit: 0 = data, 1 = command;
  - 8 payload bits, MSB first;
  - stop bit 1.
- Command payload is {1'b0, op[2:0], crc[3:0]}.
- Sampling: `sin` is sampled on every rising clk. A start bit is the first 0 sampled in IDLE.
- Idle line between packets:
  - any number of 1s is legal;
  - an all-ones gap in place of a data packet means that packet is missing, not a fault.
- FSM:
  - IDLE: sin=0 → TYPE.
  - TYPE: latch the type bit → PAYLOAD.
  - PAYLOAD: shift in 8 bits using an internal bit counter 0..7 → STOP.
  - STOP:
    - sin=1 with a data packet: shift the payload into a 64-bit {A,B} shift register; increment the data count, saturating at 15; → IDLE.
    - sin=1 with a command packet: → RESULT.
    - sin=0: pulse err_frame for one cycle; clear the data count, shift register and CRC; → IDLE.
  - RESULT: one cycle; drive out_valid=1 and the error flags; clear the frame state; → IDLE.
    - A sin=0 sampled in RESULT is treated as a start bit.
- CRC:
  - CRC-4, polynomial x^4+x+1, init CRC_INIT, MSB first.
  - Coverage: the 64 {A,B} bits, then 1'b1, then op[2:0] (68 bits total).
  - Updated bit-serially as data payload bits arrive; the 4 trailer bits are folded in at the command.
  - Serial step: fb = c[3]^d; c ← {c[2], c[1], c[0]^fb, fb}.
- Output timing and values:
  - out_valid, A, B and op are registered. out_valid asserts the clock after the command stop bit is sampled.
  - A and B hold their value until the next out_valid.
- Error priority:
  - err_data overrides err_crc; the two are never set together.
  - With err_data=1, A and B are don't-care. op is still the received value.
- Reset (rst_n=0 at a clock edge):
  - FSM → IDLE; all counters and the CRC cleared.
  - out_valid, err_data, err_crc, err_frame = 0; A, B, op = 0.
  - A reset mid-frame discards the partial frame with no output.
- More than DATA_PACKETS data packets before the command: err_data=1.
- Command with zero preceding data packets: err_data=1.

Test Plan:
- Full frame, A=0, B=0, op=3'b000, crc=4'b1011 → out_valid once; A=0, B=0, op=0; err_data=0, err_crc=0.
- Same frame with crc=4'b1010 → out_valid with err_crc=1, err_data=0.
- A=32'hFFFFFFFF, B=32'h00000001, op=3'b001; the last B byte is replaced by 11 idle ones; correct CRC → out_valid with err_data=1, err_crc=0.
- Stop bit of the 3rd data packet forced to 0, then a fresh correct frame A=0, B=0, op=0 → err_frame pulses once; the next frame yields out_valid with no errors.
- rst_n low for one cycle after the 5th data packet, then a full correct frame A=0, B=0, op=0 → exactly one out_valid; no error flags.
- Back-to-back frames with zero idle bits between packets: first A=32'h12345678, B=32'h9ABCDEF0 (correct CRC), then A=0, B=0, op=0 → two out_valid pulses with matching A, B and op.

Source files
------------

// File: rtl/alu_in_deserializer.sv
// Serial-to-parallel front end for the ALU input link.
// Frames are a series of 11-bit packets on sin: a start bit (0), a type bit
// (0 = data, 1 = command), 8 payload bits sent MSB first, and a stop bit (1).
// Data payloads build up operands A and B, with the first byte received ending
// up as the MSB byte of A. A command packet closes the frame and carries op
// and a CRC-4 that covers {A, B, 1'b1, op}.
// Ports:
//   clk, rst_n : clock and synchronous active-low reset
//   sin        : serial line, sampled on every rising edge; idles high
//   out_valid  : one-cycle pulse when a frame completes
//   A, B, op   : reassembled operands and operation code
//   err_data   : valid with out_valid; the data packet count was not DATA_PACKETS
//   err_crc    : valid with out_valid; the count was correct but the CRC mismatched
//   err_frame  : one-cycle pulse after a packet whose stop bit was 0
module alu_in_deserializer #(
  parameter int unsigned DATA_PACKETS = 8,
  parameter logic [3:0]  CRC_INIT     = 4'b0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sin,
  output logic        out_valid,
  output logic [31:0] A,
  output logic [31:0] B,
  output logic [2:0]  op,
  output logic        err_data,
  output logic        err_crc,
  output logic        err_frame
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned PAY_W = 8;
  localparam int unsigned SR_W  = 64;
  localparam int unsigned CRC_W = 4;
  localparam int unsigned BIT_W = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TYPE,
    S_PAYLOAD,
    S_STOP,
    S_RESULT
  } state_t;

  state_t             state, state_nxt;
  logic               is_cmd;
  logic [BIT_W-1:0]   bit_cnt;
  logic [PAY_W-1:0]   pay;
  logic [SR_W-1:0]    sr;
  logic [CNT_W-1:0]   data_cnt;
  logic [CRC_W-1:0]   crc;
  logic [CRC_W-1:0]   crc_fold_c;
  logic               cnt_bad_c;

  logic               latch_type_c;
  logic               shift_c;
  logic               data_done_c;
  logic               cmd_done_c;
  logic               frame_bad_c;
  logic               result_c;

  // One serial step of CRC-4 (x^4+x+1), MSB first.
  function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] c, input logic d);
    logic fb;
    fb = c[3] ^ d;
    return {c[2], c[1], c[0] ^ fb, fb};
  endfunction

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (!sin) state_nxt = S_TYPE;
      S_TYPE:    state_nxt = S_PAYLOAD;
      S_PAYLOAD: if (bit_cnt == BIT_W'(PAY_W - 1)) state_nxt = S_STOP;
      S_STOP:    state_nxt = (sin && is_cmd) ? S_RESULT : S_IDLE;
      // A 0 sampled in the result cycle is already the next start bit.
      S_RESULT:  state_nxt = sin ? S_IDLE : S_TYPE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Datapath strobes decoded from the current state.
  always_comb begin
    latch_type_c = 1'b0;
    shift_c      = 1'b0;
    data_done_c  = 1'b0;
    cmd_done_c   = 1'b0;
    frame_bad_c  = 1'b0;
    result_c     = 1'b0;
    case (state)
      S_TYPE:    latch_type_c = 1'b1;
      S_PAYLOAD: shift_c      = 1'b1;
      S_STOP: begin
        data_done_c = sin && !is_cmd;
        cmd_done_c  = sin && is_cmd;
        frame_bad_c = !sin;
      end
      S_RESULT:  result_c     = 1'b1;
      default: ;
    endcase
  end

  // Fold the trailer {1'b1, op} into the running data CRC.
  always_comb begin
    crc_fold_c = crc_step(crc_step(crc_step(crc_step(crc, 1'b1), pay[6]), pay[5]), pay[4]);
    cnt_bad_c  = (data_cnt != CNT_W'(DATA_PACKETS));
  end

  // Frame datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      is_cmd    <= 1'b0;
      bit_cnt   <= '0;
      pay       <= '0;
      sr        <= '0;
      data_cnt  <= '0;
      crc       <= CRC_INIT;
      out_valid <= 1'b0;
      A         <= '0;
      B         <= '0;
      op        <= '0;
      err_data  <= 1'b0;
      err_crc   <= 1'b0;
      err_frame <= 1'b0;
    end else begin
      out_valid <= cmd_done_c;
      err_frame <= frame_bad_c;
      err_data  <= cmd_done_c && cnt_bad_c;
      err_crc   <= cmd_done_c && !cnt_bad_c && (crc_fold_c != pay[3:0]);

      if (latch_type_c) is_cmd <= sin;

      if (shift_c) begin
        pay     <= {pay[PAY_W-2:0], sin};
        bit_cnt <= bit_cnt + BIT_W'(1);
        if (!is_cmd) crc <= crc_step(crc, sin);
      end

      if (data_done_c) begin
        sr <= {sr[SR_W-PAY_W-1:0], pay};
        if (data_cnt != '1) data_cnt <= data_cnt + CNT_W'(1);
      end

      if (cmd_done_c) begin
        A  <= sr[SR_W-1:SR_W/2];
        B  <= sr[SR_W/2-1:0];
        op <= pay[6:4];
      end

      // A broken packet or a delivered result both start a fresh frame.
      if (frame_bad_c || result_c) begin
        data_cnt <= '0;
        sr       <= '0;
        crc      <= CRC_INIT;
      end
    end
  end

endmodule

// File: tb/tb_alu_in_deserializer.sv
// Testbench for alu_in_deserializer: directed frames from the test plan followed
// by randomized frames, all compared against a reference model in the bench.
module tb_alu_in_deserializer;

  logic        clk;
  logic        rst_n;
  logic        sin;
  logic        out_valid;
  logic [31:0] A;
  logic [31:0] B;
  logic [2:0]  op;
  logic        err_data;
  logic        err_crc;
  logic        err_frame;

  alu_in_deserializer dut (
    .clk(clk), .rst_n(rst_n), .sin(sin), .out_valid(out_valid),
    .A(A), .B(B), .op(op), .err_data(err_data), .err_crc(err_crc),
    .err_frame(err_frame)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic        ed;
    logic        ec;
  } res_t;

  res_t       got[$];
  int         frame_errs = 0;
  int         stray_errs = 0;
  int         tests = 0;
  int         fails = 0;
  logic [7:0] tx_bytes[$];

  // Record every out_valid cycle and every err_frame cycle.
  always @(negedge clk) begin
    if (out_valid) got.push_back('{a: A, b: B, op: op, ed: err_data, ec: err_crc});
    if (err_frame) frame_errs++;
    if ((err_data || err_crc) && !out_valid) stray_errs++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // CRC as the remainder of the augmented message divided by x^4+x+1.
  // A nonzero initial register is equivalent to XOR-ing it into the leading bits.
  function automatic logic [3:0] model_crc(input logic [31:0] a, input logic [31:0] b,
                                           input logic [2:0] o);
    logic [71:0] m;
    m = {a, b, 1'b1, o, 4'b0000};
    m[71:68] = m[71:68] ^ 4'b0000;
    for (int i = 71; i >= 4; i--)
      if (m[i]) m[i -: 5] = m[i -: 5] ^ 5'b10011;
    return m[3:0];
  endfunction

  task automatic bit_out(input logic b);
    @(negedge clk);
    sin = b;
  endtask

  task automatic idle(input int n);
    repeat (n) bit_out(1'b1);
  endtask

  task automatic packet(input logic typ, input logic [7:0] p, input logic stop);
    bit_out(1'b0);
    bit_out(typ);
    for (int i = 7; i >= 0; i--) bit_out(p[i]);
    bit_out(stop);
  endtask

  task automatic load_ab(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] v;
    v = {a, b};
    tx_bytes.delete();
    for (int i = 7; i >= 0; i--) tx_bytes.push_back(v[i*8 +: 8]);
  endtask

  task automatic send_frame(input logic [2:0] o, input logic [3:0] c, input int gap);
    foreach (tx_bytes[i]) begin
      packet(1'b0, tx_bytes[i], 1'b1);
      idle(gap);
    end
    packet(1'b1, {1'b0, o, c}, 1'b1);
  endtask

  // Let the result drain, then expect exactly one out_valid with these fields.
  task automatic expect_one(input string tag, input logic ed, input logic ec,
                            input logic [31:0] a, input logic [31:0] b,
                            input logic [2:0] o, input logic chk_ab);
    res_t r;
    idle(3);
    check({tag, "_count"}, 64'(got.size()), 64'd1);
    if (got.size() > 0) begin
      r = got.pop_front();
      check({tag, "_err_data"}, 64'(r.ed), 64'(ed));
      check({tag, "_err_crc"}, 64'(r.ec), 64'(ec));
      check({tag, "_op"}, 64'(r.op), 64'(o));
      if (chk_ab) begin
        check({tag, "_A"}, 64'(r.a), 64'(a));
        check({tag, "_B"}, 64'(r.b), 64'(b));
      end
    end
    got.delete();
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic [2:0]  rop;
    logic [3:0]  rc;
    int          mode, n, fe0;
    logic        ed, ec;

    sin   = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_A", 64'(A), 64'd0);
    check("rst_B", 64'(B), 64'd0);
    check("rst_op", 64'(op), 64'd0);
    check("rst_errs", 64'({err_data, err_crc, err_frame}), 64'd0);
    rst_n = 1'b1;
    idle(2);

    // Zero frame with correct CRC.
    load_ab(32'h0, 32'h0);
    send_frame(3'b000, 4'b1011, 1);
    expect_one("zero_ok", 1'b0, 1'b0, 32'h0, 32'h0, 3'b000, 1'b1);

    // Same frame with a bad CRC.
    load_ab(32'h0, 32'h0);
    send_frame(3'b000, 4'b1010, 1);
    expect_one("zero_badcrc", 1'b0, 1'b1, 32'h0, 32'h0, 3'b000, 1'b1);

    // Last B byte replaced by an all-ones gap.
    load_ab(32'hFFFF_FFFF, 32'h0000_0001);
    rc = model_crc(32'hFFFF_FFFF, 32'h0000_0001, 3'b001);
    void'(tx_bytes.pop_back());
    foreach (tx_bytes[i]) begin
      packet(1'b0, tx_bytes[i], 1'b1);
      idle(1);
    end
    idle(11);
    packet(1'b1, {1'b0, 3'b001, rc}, 1'b1);
    expect_one("missing_pkt", 1'b1, 1'b0, 32'h0, 32'h0, 3'b001, 1'b0);

    // Broken stop bit on the third data packet, then a clean frame.
    fe0 = frame_errs;
    packet(1'b0, 8'hA5, 1'b1);
    packet(1'b0, 8'h5A, 1'b1);
    packet(1'b0, 8'h3C, 1'b0);
    idle(2);
    check("frame_err_pulse", 64'(frame_errs - fe0), 64'd1);
    check("frame_err_no_result", 64'(got.size()), 64'd0);
    load_ab(32'h0, 32'h0);
    send_frame(3'b000, 4'b1011, 0);
    expect_one("after_frame_err", 1'b0, 1'b0, 32'h0, 32'h0, 3'b000, 1'b1);

    // Reset after the fifth data packet discards the partial frame.
    for (int i = 0; i < 5; i++) packet(1'b0, 8'(i + 1), 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);
    check("midreset_no_result", 64'(got.size()), 64'd0);
    load_ab(32'h0, 32'h0);
    send_frame(3'b000, 4'b1011, 0);
    expect_one("after_reset", 1'b0, 1'b0, 32'h0, 32'h0, 3'b000, 1'b1);

    // Back-to-back frames with no idle bits anywhere.
    load_ab(32'h1234_5678, 32'h9ABC_DEF0);
    send_frame(3'b101, model_crc(32'h1234_5678, 32'h9ABC_DEF0, 3'b101), 0);
    load_ab(32'h0, 32'h0);
    send_frame(3'b000, 4'b1011, 0);
    idle(3);
    check("b2b_count", 64'(got.size()), 64'd2);
    if (got.size() == 2) begin
      check("b2b_1_A", 64'(got[0].a), 64'h1234_5678);
      check("b2b_1_B", 64'(got[0].b), 64'h9ABC_DEF0);
      check("b2b_1_op", 64'(got[0].op), 64'd5);
      check("b2b_1_errs", 64'({got[0].ed, got[0].ec}), 64'd0);
      check("b2b_2_A", 64'(got[1].a), 64'd0);
      check("b2b_2_op", 64'(got[1].op), 64'd0);
      check("b2b_2_errs", 64'({got[1].ed, got[1].ec}), 64'd0);
    end
    got.delete();

    // Outputs hold after the pulse.
    idle(20);
    check("hold_A", 64'(A), 64'd0);
    check("hold_out_valid", 64'(out_valid), 64'd0);

    // Command with no data packets, and one with nine.
    tx_bytes.delete();
    send_frame(3'b011, 4'b0000, 1);
    expect_one("zero_pkts", 1'b1, 1'b0, 32'h0, 32'h0, 3'b011, 1'b0);
    load_ab(32'hDEAD_BEEF, 32'hCAFE_F00D);
    tx_bytes.push_back(8'h77);
    send_frame(3'b110, 4'b0101, 1);
    expect_one("nine_pkts", 1'b1, 1'b0, 32'h0, 32'h0, 3'b110, 1'b0);

    // Randomized frames with random gaps, CRC corruption and count errors.
    for (int t = 0; t < 40; t++) begin
      ra   = $urandom;
      rb   = $urandom;
      rop  = 3'($urandom);
      mode = $urandom_range(0, 9);
      rc   = model_crc(ra, rb, rop);
      load_ab(ra, rb);
      if (mode < 2) rc = rc ^ 4'($urandom_range(1, 15));
      if (mode == 2) tx_bytes.delete($urandom_range(0, 7));
      if (mode == 3) tx_bytes.push_back(8'($urandom));
      n  = tx_bytes.size();
      ed = (n != 8);
      ec = !ed && (mode < 2);
      send_frame(rop, rc, $urandom_range(0, 2));
      expect_one($sformatf("rand%0d", t), ed, ec, ra, rb, rop, !ed);
    end

    check("stray_err_flags", 64'(stray_errs), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
